// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the integer pipeline and the iterative
// multiply/divide sequencer.
interface muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic            kill;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;
    logic            busy;

    modport master (
        output req_valid, req_op, req_a, req_b, kill, resp_ready,
        input  req_ready, resp_valid, resp_data, busy
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, kill, resp_ready,
        output req_ready, resp_valid, resp_data, busy
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide
// on magnitudes, one bit per cycle, sign fix-up afterwards.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    muldiv_seq_if.slave     bus
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_reg;
    logic [CW-1:0]     count_reg;
    logic [2*XLEN-1:0] acc_reg;
    logic [XLEN-1:0]   opnd_reg;
    logic [2:0]        op_reg;
    logic              neg_reg;
    logic              fix_phase_reg;
    logic              resp_valid_reg;
    logic [XLEN-1:0]   resp_data_reg;

    logic              accept;
    logic              a_signed;
    logic              b_signed;
    logic              sign_a;
    logic              sign_b;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic              neg_next;
    logic              div_zero;
    logic              div_ovf;
    logic              special;
    logic [XLEN-1:0]   special_data;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] div_next;

    logic [XLEN-1:0]   acc_hi;
    logic [XLEN-1:0]   acc_lo;
    logic [XLEN-1:0]   hi_neg;
    logic [XLEN-1:0]   lo_neg;
    logic [2*XLEN-1:0] acc_neg;
    logic [2*XLEN-1:0] fix_val;
    logic              sel_hi;

    assign bus.req_ready  = (state_reg == IDLE) & ~bus.kill;
    assign bus.busy       = (state_reg != IDLE);
    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_data  = resp_data_reg;

    assign accept = bus.req_valid & bus.req_ready;

    // Operand decode and special-case detection on the incoming request
    always_comb begin
        a_signed = (bus.req_op == 3'd1) | (bus.req_op == 3'd2) |
                   (bus.req_op == 3'd4) | (bus.req_op == 3'd6);
        b_signed = (bus.req_op == 3'd1) | (bus.req_op == 3'd4) |
                   (bus.req_op == 3'd6);
        sign_a   = a_signed & bus.req_a[XLEN-1];
        sign_b   = b_signed & bus.req_b[XLEN-1];
        abs_a    = sign_a ? (~bus.req_a + 1'b1) : bus.req_a;
        abs_b    = sign_b ? (~bus.req_b + 1'b1) : bus.req_b;
        // Remainder follows the dividend; everything else follows the product sign.
        if (bus.req_op[2] & bus.req_op[1]) begin
            neg_next = sign_a;
        end else begin
            neg_next = sign_a ^ sign_b;
        end
        div_zero = bus.req_op[2] & (bus.req_b == '0);
        div_ovf  = ((bus.req_op == 3'd4) | (bus.req_op == 3'd6)) &
                   (bus.req_a == {1'b1, {(XLEN-1){1'b0}}}) &
                   (bus.req_b == {XLEN{1'b1}});
        special  = div_zero | div_ovf;

        special_data = '0;
        if (div_zero) begin
            special_data = bus.req_op[1] ? bus.req_a : {XLEN{1'b1}};
        end else if (div_ovf) begin
            special_data = bus.req_op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // One iteration of shift-add multiply or restoring divide
    always_comb begin
        mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} +
                    (acc_reg[0] ? {1'b0, opnd_reg} : {(XLEN+1){1'b0}});
        mul_next  = {mul_sum, acc_reg[XLEN-1:1]};
        div_shift = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_reg};
        if (div_diff[XLEN]) begin
            div_next = {div_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0};
        end else begin
            div_next = {div_diff[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
        end
    end

    // Sign correction: full-width for products, per half for {rem, quo}
    always_comb begin
        acc_hi  = acc_reg[2*XLEN-1:XLEN];
        acc_lo  = acc_reg[XLEN-1:0];
        hi_neg  = ~acc_hi + 1'b1;
        lo_neg  = ~acc_lo + 1'b1;
        acc_neg = ~acc_reg + 1'b1;
        if (!neg_reg) begin
            fix_val = acc_reg;
        end else if (op_reg[2]) begin
            fix_val = {hi_neg, lo_neg};
        end else begin
            fix_val = acc_neg;
        end
        // MUL and the quotient ops take the low half; MULH* and REM* the high half.
        sel_hi = (op_reg != 3'd0) & ~(op_reg[2] & ~op_reg[1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            acc_reg        <= '0;
            opnd_reg       <= '0;
            op_reg         <= '0;
            neg_reg        <= 1'b0;
            fix_phase_reg  <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_data_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        op_reg        <= bus.req_op;
                        neg_reg       <= neg_next;
                        count_reg     <= '0;
                        fix_phase_reg <= 1'b0;
                        if (special) begin
                            resp_data_reg  <= special_data;
                            resp_valid_reg <= 1'b1;
                            state_reg      <= DONE;
                        end else begin
                            acc_reg   <= {{XLEN{1'b0}}, (bus.req_op[2] ? abs_a : abs_b)};
                            opnd_reg  <= bus.req_op[2] ? abs_b : abs_a;
                            state_reg <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (bus.kill) begin
                        count_reg <= '0;
                        state_reg <= IDLE;
                    end else begin
                        acc_reg <= op_reg[2] ? div_next : mul_next;
                        if (count_reg == CW'(XLEN-1)) begin
                            count_reg <= '0;
                            state_reg <= FIX;
                        end else begin
                            count_reg <= count_reg + 1'b1;
                        end
                    end
                end
                FIX: begin
                    if (bus.kill) begin
                        fix_phase_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end else if (!fix_phase_reg) begin
                        acc_reg       <= fix_val;
                        fix_phase_reg <= 1'b1;
                    end else begin
                        resp_data_reg  <= sel_hi ? acc_hi : acc_lo;
                        resp_valid_reg <= 1'b1;
                        fix_phase_reg  <= 1'b0;
                        state_reg      <= DONE;
                    end
                end
                DONE: begin
                    // kill takes priority over a pending transfer
                    if (bus.kill || bus.resp_ready) begin
                        resp_valid_reg <= 1'b0;
                        state_reg      <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
